// File: rtl/pq_ntt_pkg.sv
// Shared types and constants for the NTT twiddle generator: FSM state encoding,
// stage-field width helper and the multiplier latency the sequencer is built around.
package pq_ntt_pkg;

    typedef enum logic [1:0] {
        TW_IDLE = 2'd0,
        TW_RUN  = 2'd1,
        TW_DONE = 2'd2
    } tw_state_e;

    // The sequencer advances omega in the same cycle a beat is accepted.
    localparam int MONTMUL_LATENCY = 0;

    function automatic int tw_logw(input int max_log_n);
        return $clog2(max_log_n + 1);
    endfunction

endpackage

// File: rtl/twiddle_gen_unit_if.sv
// Twiddle stream: valid/ready beat carrying a Montgomery-domain root power,
// its stage/index position and end-of-stage / end-of-run markers.
interface twiddle_gen_unit_if
    import pq_ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOG_N  = 10,
    parameter int LOGW       = tw_logw(MAX_LOG_N)
);
    logic                  tw_valid;
    logic                  tw_ready;
    logic [DATA_WIDTH-1:0] tw_data;
    logic [LOGW-1:0]       tw_stage;
    logic [MAX_LOG_N-2:0]  tw_idx;
    logic                  tw_last;
    logic                  tw_final;

    modport master (
        output tw_valid, tw_data, tw_stage, tw_idx, tw_last, tw_final,
        input  tw_ready
    );

    modport slave (
        input  tw_valid, tw_data, tw_stage, tw_idx, tw_last, tw_final,
        output tw_ready
    );
endinterface

// File: rtl/twiddle_gen_unit_montmul.sv
// Combinational Montgomery multiplier: res = a*b*R^-1 mod q with R = 2^(DATA_WIDTH+2),
// result fully reduced into [0,q) for inputs already below q.
module twiddle_gen_unit_montmul #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    input  logic [DATA_WIDTH+1:0] qinv_i,
    output logic [DATA_WIDTH-1:0] res_o
);
    localparam int RW = DATA_WIDTH + 2;
    localparam int UW = 2 * DATA_WIDTH + 3;

    logic [2*DATA_WIDTH-1:0] prod;
    logic [RW-1:0]           m;
    logic [UW-1:0]           sum;
    logic [DATA_WIDTH:0]     t;

    assign prod = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
    assign m    = prod[RW-1:0] * qinv_i;
    // Low RW bits of sum are zero by construction; t < 2q needs one subtraction.
    assign sum  = UW'(prod) + UW'(m) * UW'(q_i);
    assign t    = (DATA_WIDTH+1)'(sum >> RW);
    assign res_o = (t >= {1'b0, q_i}) ? DATA_WIDTH'(t - {1'b0, q_i}) : t[DATA_WIDTH-1:0];

endmodule

// File: rtl/twiddle_gen_unit.sv
// Per-stage NTT twiddle sequencer: streams 2^s successive powers of the stage root for
// each stage s < log_n. Define TWIDDLE_GEN_INV_SCALE_EN to append the n^-1 scale beat on inverse runs.
module twiddle_gen_unit
    import pq_ntt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LOG_N  = 10,
    parameter int LOGW       = $clog2(MAX_LOG_N + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] modulus,
    input  logic [DATA_WIDTH+1:0] param_MinQinvModR,
    input  logic [DATA_WIDTH-1:0] r_mod_q,
    input  logic                  tbl_we,
    input  logic                  tbl_inv,
    input  logic [LOGW-1:0]       tbl_addr,
    input  logic [DATA_WIDTH-1:0] tbl_data,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LOGW-1:0]       log_n,
    input  logic                  fwd_ntt,
    twiddle_gen_unit_if.master    tw,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);
    localparam int NENT = MAX_LOG_N + 1;
    localparam int IDXW = MAX_LOG_N - 1;

    tw_state_e             state_q, state_d;
    logic [LOGW-1:0]       stage_q, stage_d;
    logic [LOGW-1:0]       log_n_q, log_n_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] omega_q, omega_d;
    logic                  fwd_q, fwd_d;
    logic                  cfg_err_q, cfg_err_d;

    logic [DATA_WIDTH-1:0] fwd_tbl_q [NENT];
    logic [DATA_WIDTH-1:0] inv_tbl_q [NENT];

    logic [DATA_WIDTH-1:0] root;
    logic [DATA_WIDTH-1:0] mul_res;
    logic [DATA_WIDTH-1:0] omega_step;
    logic [IDXW:0]         stage_span;
    logic [IDXW-1:0]       idx_max;
    logic                  scale_pending;
    logic                  scale_beat;
    logic                  last_stage;
    logic                  at_last;
    logic                  is_final;
    logic                  is_run;
    logic                  accept;
    logic                  log_n_ok;

    // Tables are only writable while idle so a running sequence never sees a torn root.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) begin
                fwd_tbl_q[i] <= '0;
                inv_tbl_q[i] <= '0;
            end
        end else if (tbl_we && (state_q == TW_IDLE) && (tbl_addr <= LOGW'(MAX_LOG_N))) begin
            if (tbl_inv) begin
                inv_tbl_q[tbl_addr] <= tbl_data;
            end else begin
                fwd_tbl_q[tbl_addr] <= tbl_data;
            end
        end
    end

    assign root = fwd_q ? fwd_tbl_q[stage_q] : inv_tbl_q[stage_q];

    twiddle_gen_unit_montmul #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_montmul (
        .a_i    (omega_q),
        .b_i    (root),
        .q_i    (modulus),
        .qinv_i (param_MinQinvModR),
        .res_o  (mul_res)
    );

    // Only a zero-latency multiplier fits the one-beat-per-cycle update below.
    generate
        if (MONTMUL_LATENCY == 0) begin : g_mul_comb
            assign omega_step = mul_res;
        end else begin : g_mul_unsupported
            assign omega_step = '0;
        end
    endgenerate

`ifdef TWIDDLE_GEN_INV_SCALE_EN
    assign scale_pending = ~fwd_q;
`else
    assign scale_pending = 1'b0;
`endif

    assign stage_span = (IDXW+1)'(1) << stage_q;
    assign idx_max    = IDXW'(stage_span - (IDXW+1)'(1));
    // Stage index equal to log_n is only reachable as the trailing scale beat.
    assign scale_beat = (stage_q == log_n_q);
    assign last_stage = (stage_q == (log_n_q - LOGW'(1)));
    assign at_last    = scale_beat || (idx_q == idx_max);
    assign is_final   = at_last && (scale_beat || (last_stage && !scale_pending));
    assign is_run     = (state_q == TW_RUN);
    assign accept     = is_run && tw.tw_ready;
    assign log_n_ok   = (log_n != '0) && (log_n <= LOGW'(MAX_LOG_N));

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        log_n_d   = log_n_q;
        idx_d     = idx_q;
        omega_d   = omega_q;
        fwd_d     = fwd_q;
        cfg_err_d = cfg_err_q;
        if (abort) begin
            state_d = TW_IDLE;
        end else begin
            unique case (state_q)
                TW_IDLE: begin
                    if (start) begin
                        if (log_n_ok) begin
                            state_d   = TW_RUN;
                            log_n_d   = log_n;
                            fwd_d     = fwd_ntt;
                            stage_d   = '0;
                            idx_d     = '0;
                            omega_d   = r_mod_q;
                            cfg_err_d = 1'b0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                TW_RUN: begin
                    if (accept) begin
                        if (is_final) begin
                            state_d = TW_DONE;
                        end
                        if (at_last) begin
                            idx_d   = '0;
                            stage_d = stage_q + LOGW'(1);
                            omega_d = (last_stage && scale_pending) ? inv_tbl_q[0] : r_mod_q;
                        end else begin
                            idx_d   = idx_q + IDXW'(1);
                            omega_d = omega_step;
                        end
                    end
                end
                TW_DONE: state_d = TW_IDLE;
                default: state_d = TW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TW_IDLE;
            stage_q   <= '0;
            log_n_q   <= '0;
            idx_q     <= '0;
            omega_q   <= '0;
            fwd_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            log_n_q   <= log_n_d;
            idx_q     <= idx_d;
            omega_q   <= omega_d;
            fwd_q     <= fwd_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign tw.tw_valid = is_run;
    assign tw.tw_data  = omega_q;
    assign tw.tw_stage = stage_q;
    assign tw.tw_idx   = idx_q;
    assign tw.tw_last  = is_run && at_last;
    assign tw.tw_final = is_run && is_final;

    assign busy    = (state_q != TW_IDLE);
    assign done    = (state_q == TW_DONE) && !abort;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_twiddle_gen_unit.sv
// Scoreboard bench for twiddle_gen_unit: stimulus pushes expected beats, a monitor pops
// and compares each accepted beat, checks stall stability and the done pulse.
module tb_twiddle_gen_unit;
    localparam int DW  = 16;
    localparam int MLN = 10;
    localparam int LW  = 4;
    localparam longint unsigned Q     = 7681;
    localparam longint unsigned RMASK = (64'd1 << (DW + 2)) - 1;

`ifdef TWIDDLE_GEN_INV_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0]    data;
        logic [LW-1:0]    stage;
        logic [MLN-2:0]   idx;
        logic             last;
        logic             fin;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   modulus;
    logic [DW+1:0]   minq;
    logic [DW-1:0]   r_mod_q;
    logic            tbl_we, tbl_inv;
    logic [LW-1:0]   tbl_addr;
    logic [DW-1:0]   tbl_data;
    logic            start, abort, fwd_ntt;
    logic [LW-1:0]   log_n;
    logic            busy, done, cfg_err;

    twiddle_gen_unit_if #(.DATA_WIDTH(DW), .MAX_LOG_N(MLN), .LOGW(LW)) tw_if ();

    twiddle_gen_unit #(.DATA_WIDTH(DW), .MAX_LOG_N(MLN), .LOGW(LW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .modulus           (modulus),
        .param_MinQinvModR (minq),
        .r_mod_q           (r_mod_q),
        .tbl_we            (tbl_we),
        .tbl_inv           (tbl_inv),
        .tbl_addr          (tbl_addr),
        .tbl_data          (tbl_data),
        .start             (start),
        .abort             (abort),
        .log_n             (log_n),
        .fwd_ntt           (fwd_ntt),
        .tw                (tw_if),
        .busy              (busy),
        .done              (done),
        .cfg_err           (cfg_err)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          accepted = 0;
    bit          ready_rand = 1'b0;
    int unsigned fwd_tbl [MLN+1];
    int unsigned inv_tbl [MLN+1];
    int unsigned rmodq;

    function automatic longint unsigned powmod(input longint unsigned b, input longint unsigned e);
        longint unsigned r = 1;
        longint unsigned x = b % Q;
        longint unsigned k = e;
        while (k != 0) begin
            if (k[0]) r = (r * x) % Q;
            x = (x * x) % Q;
            k = k >> 1;
        end
        return r;
    endfunction

    // a*b*2^-18 mod q by halving modulo q, independent of the REDC formulation.
    function automatic int unsigned mont_ref(input int unsigned a, input int unsigned b);
        longint unsigned x = (longint'(a) * longint'(b)) % Q;
        for (int i = 0; i < DW + 2; i++) begin
            if (x[0]) x = x + Q;
            x = x >> 1;
        end
        return int'(x);
    endfunction

    function automatic int unsigned to_mont(input longint unsigned x);
        return int'(((x % Q) << (DW + 2)) % Q);
    endfunction

    task automatic push_run(input int logn, input bit fwd);
        beat_t b;
        int unsigned w, rt;
        bit scale;
        scale = SCALE_EN && !fwd;
        for (int s = 0; s < logn; s++) begin
            rt = fwd ? fwd_tbl[s] : inv_tbl[s];
            w  = rmodq;
            for (int i = 0; i < (1 << s); i++) begin
                b.data  = DW'(w);
                b.stage = LW'(s);
                b.idx   = (MLN-1)'(i);
                b.last  = (i == (1 << s) - 1);
                b.fin   = b.last && (s == logn - 1) && !scale;
                exp_q.push_back(b);
                w = mont_ref(w, rt);
            end
        end
        if (scale) begin
            b.data = DW'(inv_tbl[0]); b.stage = LW'(logn); b.idx = '0; b.last = 1'b1; b.fin = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end else begin
            $display("check %s: %0d ok", name, got);
        end
    endtask

    task automatic do_start(input int logn, input bit fwd);
        start = 1'b1; log_n = LW'(logn); fwd_ntt = fwd;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_run(input string name, input int base, input int nbeats, input int maxc);
        int c = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && c < maxc) begin
            tick();
            c++;
        end
        if (c >= maxc) begin
            checks++; errors++;
            $display("FAIL %s_timeout: still busy or %0d beats outstanding after %0d cycles, required idle", name, exp_q.size(), maxc);
            exp_q.delete();
        end
        check({name, "_beats"}, accepted - base, nbeats);
    endtask

    task automatic write_tbl(input bit inv, input int addr, input int unsigned data);
        tbl_we = 1'b1; tbl_inv = inv; tbl_addr = LW'(addr); tbl_data = DW'(data);
        tick();
        tbl_we = 1'b0;
    endtask

    // Monitor: pops one expected beat per handshake, checks stall stability and done timing.
    initial begin : monitor
        beat_t held, cur, e;
        bit hold_valid = 1'b0;
        bit expect_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_valid = 1'b0;
                expect_done = 1'b0;
            end else begin
                if (expect_done) begin
                    checks++;
                    if (done !== 1'b1 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL done_pulse: done=%b busy=%b, required done=1 busy=1", done, busy);
                    end else begin
                        $display("done pulse after final beat ok");
                    end
                    expect_done = 1'b0;
                end else if (done !== 1'b0) begin
                    checks++; errors++;
                    $display("FAIL spurious_done: done=%b, required 0", done);
                end
                cur.data = tw_if.tw_data; cur.stage = tw_if.tw_stage; cur.idx = tw_if.tw_idx;
                cur.last = tw_if.tw_last; cur.fin = tw_if.tw_final;
                if (tw_if.tw_valid === 1'b1) begin
                    if (hold_valid) begin
                        checks++;
                        if (cur.data !== held.data || cur.stage !== held.stage || cur.idx !== held.idx ||
                            cur.last !== held.last || cur.fin !== held.fin) begin
                            errors++;
                            $display("FAIL stall_stable: got data=%0d stage=%0d idx=%0d, required data=%0d stage=%0d idx=%0d",
                                     cur.data, cur.stage, cur.idx, held.data, held.stage, held.idx);
                        end
                    end
                    if (tw_if.tw_ready === 1'b1) begin
                        hold_valid = 1'b0;
                        accepted++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_beat: got data=%0d stage=%0d idx=%0d, required no beat",
                                     cur.data, cur.stage, cur.idx);
                        end else begin
                            e = exp_q.pop_front();
                            if (cur.data !== e.data || cur.stage !== e.stage || cur.idx !== e.idx ||
                                cur.last !== e.last || cur.fin !== e.fin) begin
                                errors++;
                                $display("FAIL beat: got data=%0d stage=%0d idx=%0d last=%b final=%b, required data=%0d stage=%0d idx=%0d last=%b final=%b",
                                         cur.data, cur.stage, cur.idx, cur.last, cur.fin, e.data, e.stage, e.idx, e.last, e.fin);
                            end else begin
                                $display("beat stage=%0d idx=%0d data=%0d last=%b final=%b ok",
                                         cur.stage, cur.idx, cur.data, cur.last, cur.fin);
                            end
                        end
                        if (cur.fin === 1'b1) expect_done = 1'b1;
                    end else begin
                        held = cur;
                        hold_valid = 1'b1;
                    end
                end else begin
                    hold_valid = 1'b0;
                end
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) tw_if.tw_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        longint unsigned inv, y, rt;
        int base, c;
        inv = Q;
        repeat (5) inv = (inv * ((64'd2 - ((Q * inv) & RMASK)) & RMASK)) & RMASK;
        minq    = (DW+2)'(((RMASK + 1) - inv) & RMASK);
        rmodq   = int'((64'd1 << (DW + 2)) % Q);
        modulus = DW'(Q);
        r_mod_q = DW'(rmodq);
        // Element of order 512: (q-1)/512 = 15.
        y = 0;
        for (int x = 2; x < 200; x++) begin
            y = powmod(longint'(x), 15);
            if (powmod(y, 256) == Q - 1) break;
        end
        for (int s = 0; s <= MLN; s++) begin
            if (s <= 8) begin
                rt = powmod(y, longint'(1) << (8 - s));
                fwd_tbl[s] = to_mont(rt);
                inv_tbl[s] = to_mont(powmod(rt, Q - 2));
            end else begin
                fwd_tbl[s] = to_mont(longint'(s));
                inv_tbl[s] = to_mont(longint'(s + 7));
            end
        end
        inv_tbl[0] = 7651;

        tbl_we = 0; tbl_inv = 0; tbl_addr = '0; tbl_data = '0;
        start = 0; abort = 0; log_n = '0; fwd_ntt = 0;
        tw_if.tw_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_valid", tw_if.tw_valid, 0);
        check("rst_data", tw_if.tw_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        tick();

        for (int a = 0; a <= MLN; a++) write_tbl(1'b0, a, fwd_tbl[a]);
        for (int a = 0; a <= MLN; a++) write_tbl(1'b1, a, inv_tbl[a]);

        // Forward log_n=8, continuous ready.
        tw_if.tw_ready = 1'b1;
        base = accepted; push_run(8, 1'b1); do_start(8, 1'b1);
        wait_run("fwd8", base, 255, 600);

        // Same run under random backpressure.
        ready_rand = 1'b1;
        base = accepted; push_run(8, 1'b1); do_start(8, 1'b1);
        wait_run("fwd8_rand", base, 255, 4000);
        ready_rand = 1'b0;
        tw_if.tw_ready = 1'b1;

        // Illegal log_n values.
        do_start(0, 1'b1);
        check("cfg0_err", cfg_err, 1); check("cfg0_busy", busy, 0); check("cfg0_valid", tw_if.tw_valid, 0);
        do_start(11, 1'b1);
        check("cfg11_err", cfg_err, 1); check("cfg11_busy", busy, 0); check("cfg11_valid", tw_if.tw_valid, 0);
        base = accepted; push_run(2, 1'b1); do_start(2, 1'b1);
        check("cfg_err_clear", cfg_err, 0);
        wait_run("cfg_recover", base, 3, 50);

        // Abort at stage 3 idx 2 while stalled.
        base = accepted; push_run(8, 1'b1); do_start(8, 1'b1);
        c = 0;
        while (accepted - base < 9 && c < 200) begin tick(); c++; end
        tw_if.tw_ready = 1'b0; abort = 1'b1;
        check("abort_stage", tw_if.tw_stage, 3);
        check("abort_idx", tw_if.tw_idx, 2);
        tick();
        abort = 1'b0;
        check("abort_valid", tw_if.tw_valid, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        repeat (3) tick();
        tw_if.tw_ready = 1'b1;
        base = accepted; push_run(3, 1'b1); do_start(3, 1'b1);
        wait_run("replay", base, 7, 100);

        // Table writes during a run must not affect it.
        base = accepted; push_run(6, 1'b1); do_start(6, 1'b1);
        for (int k = 1; k <= 5; k++) write_tbl(1'b0, k, int'(k * 3 + 1));
        wait_run("we_busy", base, 63, 300);

        // Inverse run (adds the scale beat when the feature is built in).
        base = accepted; push_run(8, 1'b0); do_start(8, 1'b0);
        wait_run("inv8", base, SCALE_EN ? 256 : 255, 600);

        // Reset mid-run: run discarded, tables cleared.
        base = accepted; push_run(5, 1'b1); do_start(5, 1'b1);
        repeat (10) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", tw_if.tw_valid, 0);
        check("midrst_data", tw_if.tw_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int a = 0; a <= MLN; a++) begin fwd_tbl[a] = 0; inv_tbl[a] = 0; end
        base = accepted; push_run(2, 1'b1); do_start(2, 1'b1);
        wait_run("post_reset", base, 3, 50);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/twiddle_gen_unit.md
TWIDDLE_GEN_UNIT -- requirements
Module: twiddle_gen_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: coefficient/twiddle width.
REQ-002 SHALL have parameter MAX_LOG_N, default 10: largest supported log2(n).
REQ-003 SHALL have parameter LOGW, default $clog2(MAX_LOG_N+1): width of stage/log_n fields.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 modulus  in  DATA_WIDTH  q; param_MinQinvModR  in  DATA_WIDTH+2  -q^-1 mod R; r_mod_q  in  DATA_WIDTH  Montgomery one.
REQ-007 tbl_we  in  1; tbl_inv  in  1 (0 fwd table, 1 inv table); tbl_addr  in  LOGW; tbl_data  in  DATA_WIDTH  table write port.
REQ-008 start  in  1; abort  in  1; log_n  in  LOGW; fwd_ntt  in  1  sampled at start.
REQ-009 tw_valid  out  1; tw_ready  in  1; tw_data  out  DATA_WIDTH; tw_stage  out  LOGW; tw_idx  out  MAX_LOG_N-1  twiddle stream.
REQ-010 tw_last  out  1 (last beat of stage); tw_final  out  1 (last beat of run); busy  out  1; done  out  1 (one-cycle pulse); cfg_err  out  1 (sticky).

Function
REQ-011 SHALL hold two tables of MAX_LOG_N+1 entries (fwd, inv) of Montgomery-domain per-stage roots; entry s = primitive 2^(s+1)-th root (or inverse) times R mod q.
REQ-012 Table writes SHALL take effect only when FSM is IDLE; tbl_we while busy SHALL be ignored.
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on start when 1 <= log_n <= MAX_LOG_N; latch log_n, fwd_ntt; stage=0, idx=0, omega=r_mod_q.
REQ-015 start with log_n 0 or > MAX_LOG_N SHALL set cfg_err, stay IDLE; cfg_err cleared only by next valid start.
REQ-016 In RUN, tw_valid=1, tw_data=omega, tw_stage=stage, tw_idx=idx; stage s emits exactly 2^s beats, idx 0..2^s-1.
REQ-017 On tw_valid&tw_ready: if idx<2^s-1, omega <= MontMul(omega, table[s]), idx++; else omega <= r_mod_q, idx=0, stage++.
REQ-018 MontMul SHALL be the existing combinational multiplier: result = a*b*R^-1 mod q, fully reduced to [0,q).
REQ-019 tw_last=1 when idx=2^s-1; tw_final=1 when additionally s=log_n-1 (and no scale beat pending, REQ-028).
REQ-020 With tw_ready=0, all tw_* outputs SHALL hold stable; no internal state changes.
REQ-021 Accept of tw_final beat -> DONE; DONE asserts done for one cycle, then IDLE; busy=1 in RUN and DONE.
REQ-022 abort SHALL have priority over every other event: next state IDLE, tw_valid=0, no done pulse.
REQ-023 start while busy SHALL be ignored.
REQ-024 Total beats per run: 2^log_n - 1 (plus one if REQ-028 active); no bubble between beats under continuous ready.

Reset
REQ-025 On rst_n low: FSM IDLE, omega=0, stage=0, idx=0, tw_valid=0, busy=0, done=0, cfg_err=0, tw_data=0.
REQ-026 Both tables SHALL reset to 0; reset mid-run SHALL discard the run with no done pulse.

Configuration
REQ-027 Macro TWIDDLE_GEN_INV_SCALE_EN selects inverse-scale beat support.
REQ-028 Defined: when fwd_ntt=0, after last stage beat one extra beat with tw_data=inv table entry MAX_LOG_N-ish slot addressed by tbl_addr=0 reinterpreted as n^-1*R mod q (inv table entry 0), tw_stage=log_n, tw_idx=0, tw_last=1, tw_final=1; undefined: no extra beat, inv entry 0 used only as a root.

Structure
REQ-029 Package pq_ntt_pkg SHALL hold state enum typedef, LOGW helper function and MontMul latency constant (0).
REQ-030 One sub-module: existing multiplier instance; table storage and FSM stay in twiddle_gen_unit.

Verification
REQ-031 q=7681, r_mod_q=990, log_n=8, fwd, ready=1: 255 beats; first beat of each stage=990; second beat of stage s = fwd table[s]; done one cycle after final.
REQ-032 Random tw_ready (50%): beat sequence identical to REQ-031 scenario, outputs stable while ready=0.
REQ-033 start with log_n=0 and log_n=11: cfg_err=1, busy=0, no tw_valid; then valid start clears cfg_err.
REQ-034 abort at stage 3 idx 2 asserted with tw_ready=0: next cycle IDLE, tw_valid=0, no done pulse; new start replays from stage 0.
REQ-035 tbl_we during RUN with changed data: run output unchanged versus golden model.
REQ-036 With TWIDDLE_GEN_INV_SCALE_EN, fwd_ntt=0, log_n=8, inv entry 0 = 7651: 256 beats, last beat tw_data=7651, tw_stage=8, tw_final=1.
